// File: rtl/fp_accum_ctrl_pkg.sv
// ============================================================================
// Module  : fp_accum_ctrl_pkg
// Brief   : Shared constants and state type for the fp32 reduction scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fp_accum_ctrl_pkg;

    localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE    = 32'h3F80_0000;

    localparam int          DEF_ADD_LAT = 11;
    localparam int          DEF_MUL_LAT = 6;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_accum_ctrl_valid_pipe.sv
// ============================================================================
// Module  : accum_valid_pipe
// Brief   : DEPTH-stage 1-bit delay line marking which adder results are real.
// Revision: 1.0
// ============================================================================
`default_nettype none

module accum_valid_pipe
    import fp_accum_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_ADD_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fp_accum_ctrl.sv
// ============================================================================
// Module  : fp_accum_ctrl
// Brief   : Schedules a shared pipelined fp32 adder to reduce a stream to one sum.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_accum_ctrl
    import fp_accum_ctrl_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_res,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int IF_W = $clog2(ADD_LAT + 2);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_hold;
    logic              r_hold_v;
    logic              r_issue_q;
    logic [IF_W-1:0]   r_inflight;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_acc;
    logic              w_ret;
    logic              w_issue;
    logic [31:0]       w_op_a;
    logic [31:0]       w_op_b;
    logic              w_hold_ld;
    logic              w_hold_clr;
    logic [31:0]       w_hold_d;
    logic              w_hold_v_nxt;
    logic [IF_W-1:0]   w_inflight_nxt;
    logic              w_done;

    // The operand register itself is the first latency stage, so the
    // delay line is fed from the registered issue flag.
    accum_valid_pipe #(
        .DEPTH (ADD_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (r_issue_q),
        .dout  (w_ret)
    );

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == OUT);
    assign w_acc     = in_valid && in_ready;

    always_comb begin
        w_issue    = 1'b0;
        w_op_a     = add_res;
        w_op_b     = in_data;
        w_hold_ld  = 1'b0;
        w_hold_clr = 1'b0;
        w_hold_d   = in_data;
        if (w_ret && w_acc) begin
            w_issue = 1'b1;
        end else if (w_ret && r_hold_v) begin
            w_issue    = 1'b1;
            w_op_b     = r_hold;
            w_hold_clr = 1'b1;
        end else if (w_acc && r_hold_v) begin
            w_issue    = 1'b1;
            w_op_a     = in_data;
            w_op_b     = r_hold;
            w_hold_clr = 1'b1;
        end else if (w_ret) begin
            w_hold_ld = 1'b1;
            w_hold_d  = add_res;
        end else if (w_acc) begin
            w_hold_ld = 1'b1;
        end
    end

    always_comb begin
        w_hold_v_nxt   = w_hold_ld ? 1'b1 : (w_hold_clr ? 1'b0 : r_hold_v);
        w_inflight_nxt = r_inflight + IF_W'(w_issue) - IF_W'(w_ret);
        w_done         = (r_state == DRAIN) && (w_inflight_nxt == '0) &&
                         !w_ret && !w_issue && w_hold_v_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_acc && in_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_done)           w_state_nxt = OUT;
            OUT:     if (out_ready)        w_state_nxt = ACCUM;
            default:                       w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_a      <= FP32_ZERO;
            add_b      <= FP32_ZERO;
            r_issue_q  <= 1'b0;
            r_inflight <= '0;
            r_hold     <= FP32_ZERO;
            r_hold_v   <= 1'b0;
            r_cnt      <= '0;
            out_data   <= FP32_ZERO;
            out_cnt    <= '0;
        end else begin
            if (w_issue) begin
                add_a <= w_op_a;
                add_b <= w_op_b;
            end
            r_issue_q  <= w_issue;
            r_inflight <= w_inflight_nxt;
            if (w_done) begin
                out_data <= r_hold;
                out_cnt  <= r_cnt;
                r_hold_v <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_hold_v <= w_hold_v_nxt;
                if (w_hold_ld) begin
                    r_hold <= w_hold_d;
                end
                if (w_acc && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_accum_ctrl.sv
// ============================================================================
// Module  : tb_fp_accum_ctrl
// Brief   : Randomised and directed bench with an fp32 adder model and a
//           sequence-level reference for the reduction scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp_accum_ctrl;
    import fp_accum_ctrl_pkg::*;

    localparam int ADD_LAT = 11;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             reset;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_res;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_cnt;
    logic             out_valid;
    logic             out_ready;

    fp_accum_ctrl #(
        .ADD_LAT (ADD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_res   (add_res),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    function automatic real fp2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic [63:0] d;
        logic [7:0]  e8;
        if (r == 0.0) return 32'h0;
        d  = $realtobits(r);
        e8 = 8'(d[62:52] - 11'd896);
        return {d[63], e8, d[51:29]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External pipelined adder: operands visible in cycle c appear on add_res
    // at the end of cycle c+ADD_LAT.
    logic [31:0] apipe [ADD_LAT+1];
    initial begin
        for (int k = 0; k <= ADD_LAT; k++) apipe[k] = 32'h0;
        add_res = 32'h0;
    end
    always @(negedge clk) begin
        for (int k = ADD_LAT; k > 0; k--) apipe[k] = apipe[k-1];
        apipe[0] = r2fp(fp2r(add_a) + fp2r(add_b));
        add_res  = apipe[ADD_LAT];
    end

    // Sequence-level reference: a sequence is busy from the cycle after its
    // last element is accepted until the cycle after its result handshake.
    real         cur_sum;
    int          cur_cnt;
    bit          busy;
    logic [31:0] exp_sum [$];
    int          exp_cnt [$];
    bit          prev_hold;
    logic [31:0] prev_data;
    logic [CNT_W-1:0] prev_cnt;
    int          drain_cyc;
    int          issue_cnt;
    logic [31:0] last_data;
    int          last_cnt;

    initial begin
        cur_sum = 0.0; cur_cnt = 0; busy = 0; prev_hold = 0;
        drain_cyc = 0; issue_cnt = 0; last_data = 32'h0; last_cnt = 0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_in_ready", 64'(in_ready), 64'd1);
            chk("reset_outs", {out_valid, add_a, 31'(out_cnt)}, 64'd0);
            chk("reset_out_data", 64'({add_b, out_data}), 64'd0);
            cur_sum = 0.0; cur_cnt = 0; busy = 0; prev_hold = 0; drain_cyc = 0;
            exp_sum.delete(); exp_cnt.delete();
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!busy));
            if (out_valid && !busy) chk("out_valid_unexpected", 64'd1, 64'd0);
            if (prev_hold && out_valid) begin
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_cnt", 64'(out_cnt), 64'(prev_cnt));
            end
            if (dut.r_inflight > ADD_LAT + 1)
                chk("inflight_bound", 64'(dut.r_inflight), 64'(ADD_LAT + 1));
            if (dut.w_issue) issue_cnt++;
            if (in_valid && !busy) begin
                cur_sum += fp2r(in_data);
                cur_cnt++;
                if (in_last) begin
                    exp_sum.push_back(r2fp(cur_sum));
                    exp_cnt.push_back(cur_cnt);
                    cur_sum = 0.0; cur_cnt = 0; busy = 1;
                end
            end else if (out_valid && out_ready) begin
                if (exp_sum.size() == 0) begin
                    chk("result_without_sequence", 64'd1, 64'd0);
                end else begin
                    chk("out_data", 64'(out_data), 64'(exp_sum.pop_front()));
                    chk("out_cnt", 64'(out_cnt), 64'(exp_cnt.pop_front()));
                end
                last_data = out_data;
                last_cnt  = int'(out_cnt);
                busy = 0;
            end
            if (busy && !out_valid) drain_cyc++; else drain_cyc = 0;
            if (drain_cyc == 300) chk("drain_timeout", 64'd1, 64'd0);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_cnt  = out_cnt;
        end
    end

    logic [31:0] seq [16];

    task automatic drive_elem(input logic [31:0] d, input bit last);
        int t;
        in_valid = 1'b1; in_data = d; in_last = last;
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 400) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_data = $urandom;
    endtask

    task automatic send_seq(input int n, input int maxgap, input bit with_last);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
            drive_elem(seq[i], with_last && (i == n - 1));
        end
    endtask

    task automatic take_result(input int stall);
        int t;
        out_ready = 1'b0;
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (t == 400) chk("result_timeout", 64'd1, 64'd0);
        repeat (stall) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; in_last = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        reset = 1'b0; in_data = 32'h0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(2);

        // Single element: held and returned without touching the adder.
        issue_cnt = 0;
        seq[0] = 32'h4040_0000;
        send_seq(1, 0, 1);
        take_result(0);
        chk("single_data", 64'(last_data), 64'h4040_0000);
        chk("single_cnt", 64'(last_cnt), 64'd1);
        chk("single_issues", 64'(issue_cnt), 64'd0);
        chk("single_add_a", 64'(add_a), 64'd0);

        // 1+2+3+4 back to back.
        issue_cnt = 0;
        seq[0] = 32'h3F80_0000; seq[1] = 32'h4000_0000;
        seq[2] = 32'h4040_0000; seq[3] = 32'h4080_0000;
        send_seq(4, 0, 1);
        take_result(0);
        chk("sum4_data", 64'(last_data), 64'h4120_0000);
        chk("sum4_cnt", 64'(last_cnt), 64'd4);
        chk("sum4_issues", 64'(issue_cnt), 64'd3);

        // Eight ones with random gaps.
        issue_cnt = 0;
        for (int i = 0; i < 8; i++) seq[i] = FP32_ONE;
        send_seq(8, 3, 1);
        take_result(0);
        chk("ones8_data", 64'(last_data), 64'h4100_0000);
        chk("ones8_cnt", 64'(last_cnt), 64'd8);
        chk("ones8_issues", 64'(issue_cnt), 64'd7);

        // Backpressure for 20 cycles with ignored input beats, then a fresh sum.
        seq[0] = FP32_ONE; seq[1] = FP32_ONE;
        send_seq(2, 0, 1);
        take_result(20);
        chk("bp_data", 64'(last_data), 64'h4000_0000);
        seq[0] = 32'h40A0_0000;
        send_seq(1, 0, 1);
        take_result(0);
        chk("bp_next_data", 64'(last_data), 64'h40A0_0000);
        chk("bp_next_cnt", 64'(last_cnt), 64'd1);

        // Reset while three additions are in flight.
        for (int i = 0; i < 6; i++) seq[i] = r2fp(real'(i + 1));
        send_seq(6, 0, 0);
        idle(2);
        chk("pre_reset_inflight", 64'(dut.r_inflight), 64'd3);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        issue_cnt = 0;
        seq[0] = 32'h4000_0000; seq[1] = 32'h4000_0000;
        send_seq(2, 0, 1);
        take_result(0);
        chk("post_reset_data", 64'(last_data), 64'h4080_0000);
        chk("post_reset_cnt", 64'(last_cnt), 64'd2);

        // 1..6 with a gap timed so a result returns alongside a new element.
        issue_cnt = 0;
        for (int i = 0; i < 6; i++) seq[i] = r2fp(real'(i + 1));
        drive_elem(seq[0], 0); drive_elem(seq[1], 0); drive_elem(seq[2], 0);
        idle(9);
        drive_elem(seq[3], 0); drive_elem(seq[4], 0); drive_elem(seq[5], 1);
        take_result(1);
        chk("sum6_data", 64'(last_data), 64'h41A8_0000);
        chk("sum6_cnt", 64'(last_cnt), 64'd6);
        chk("sum6_issues", 64'(issue_cnt), 64'd5);

        // Random sequences against the reference.
        for (int s = 0; s < 30; s++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) seq[i] = r2fp(real'($urandom_range(0, 20)));
            send_seq(n, $urandom_range(0, 4), 1);
            take_result($urandom_range(0, 3));
        end
        idle(3);
        chk("scoreboard_empty", 64'(exp_sum.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
